sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator_if.sv | 45 ++++
 rtl/sequence_generator.sv | 131 +++++++++++++
 tb/tb_sequence_generator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_if.sv
// sequence_generator_if -- bundle between a sequence_generator and whatever
// drives it.
//
// Signals:
//   start     request to begin a transmission
//   pattern   PW-bit pattern, sent MSB-first from bit len-1
//   len       pattern bits per repetition, 0..PW (larger values clamp to PW)
//   rpt       repetition count, 0 behaves as 1
//   gap       idle cycles between repetitions
//   x         serial bit stream (0 whenever frame is 0)
//   frame     x carries a pattern bit this cycle
//   busy      transmission in progress
//   done      one-cycle completion pulse
//   dbg_state current FSM state (0 IDLE, 1 SEND, 2 GAP), for checkers
//
// Handshake: start is a one-way request with no ready signal. It is taken
// only on a rising edge where busy is 0, including the done cycle. While
// busy is 1, start is ignored. pattern/len/rpt/gap are sampled only on that
// accepting edge.
interface sequence_generator_if #(
    parameter int PW = 8
);
    localparam int LW = $clog2(PW) + 1;

    logic          start;
    logic [PW-1:0] pattern;
    logic [LW-1:0] len;
    logic [3:0]    rpt;
    logic [3:0]    gap;
    logic          x;
    logic          frame;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    modport master (
        output start, pattern, len, rpt, gap,
        input  x, frame, busy, done, dbg_state
    );

    modport slave (
        input  start, pattern, len, rpt, gap,
        output x, frame, busy, done, dbg_state
    );
endinterface

// File: rtl/sequence_generator.sv
// sequence_generator -- serialises a latched bit pattern MSB-first.
// Each repetition sends len bits. Repetitions are separated by gap idle
// cycles. A done pulse follows the last bit. All outputs are registered.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, wins over start
//   bus    sequence_generator_if.slave (start/pattern/len/rpt/gap in,
//          x/frame/busy/done/dbg_state out)
module sequence_generator #(
    parameter int PW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_generator_if.slave  bus
);
    localparam int LW = $clog2(PW) + 1;
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pat_q;
    logic [LW-1:0] len_q;
    logic [3:0]    gap_q;
    logic [3:0]    rpt_left;  // repetitions left, counting the one on the wire
    logic [IW-1:0] bit_idx;   // index of the bit currently on x
    logic [3:0]    gap_cnt;   // gap cycles left, counting the current one
    logic          x_q;
    logic          frame_q;
    logic          busy_q;
    logic          done_q;

    logic [LW-1:0] len_c;
    logic [IW-1:0] top_in;
    logic [IW-1:0] top_q;

    // Clamp len to PW. The first-bit index is taken straight from the inputs,
    // so bit len-1 is on x in the cycle right after acceptance.
    assign len_c  = (bus.len > LW'(PW)) ? LW'(PW) : bus.len;
    assign top_in = IW'(len_c - LW'(1));
    assign top_q  = IW'(len_q - LW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            rpt_left <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            x_q      <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_q    <= bus.pattern;
                        len_q    <= len_c;
                        gap_q    <= bus.gap;
                        rpt_left <= (bus.rpt == 4'd0) ? 4'd1 : bus.rpt;
                        if (len_c != '0) begin
                            state   <= SEND;
                            bit_idx <= top_in;
                            x_q     <= bus.pattern[top_in];
                            frame_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            // Empty pattern: complete immediately, never busy.
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        x_q     <= pat_q[bit_idx - 1'b1];
                    end else if (rpt_left > 4'd1) begin
                        rpt_left <= rpt_left - 4'd1;
                        if (gap_q != 4'd0) begin
                            state   <= GAP;
                            gap_cnt <= gap_q;
                            x_q     <= 1'b0;
                            frame_q <= 1'b0;
                        end else begin
                            // Back-to-back repetition: restart at the top bit.
                            bit_idx <= top_q;
                            x_q     <= pat_q[top_q];
                        end
                    end else begin
                        state   <= IDLE;
                        x_q     <= 1'b0;
                        frame_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd1) begin
                        state   <= SEND;
                        bit_idx <= top_q;
                        x_q     <= pat_q[top_q];
                        frame_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    x_q     <= 1'b0;
                    frame_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x         = x_q;
    assign bus.frame     = frame_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator -- self-checking bench for sequence_generator:
// directed vector table, hand-written multi-cycle sequences, and random
// traffic compared against a per-transmission output-list model.
module tb_sequence_generator;
    localparam int PW = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    sequence_generator_if #(.PW(PW)) bus ();

    sequence_generator #(.PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: on acceptance, the whole output list is built up front.
    // Each entry is {x, frame, busy, done} for one cycle.
    logic [3:0] exp_q[$];
    logic [3:0] cur;

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] pattern;
        logic [3:0] len;
        logic [3:0] rpt;
        logic [3:0] gap;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [3:0] outs();
        return {bus.x, bus.frame, bus.busy, bus.done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [7:0] p,
                              input logic [3:0] l, input logic [3:0] rp, input logic [3:0] g);
        int n;
        int reps;
        if (r) begin
            exp_q.delete();
            cur = 4'b0000;
        end else if (!cur[1] && s) begin
            n    = (l > 4'd8) ? 8 : int'(l);
            reps = (rp == 4'd0) ? 1 : int'(rp);
            exp_q.delete();
            if (n > 0) begin
                for (int rr = 0; rr < reps; rr++) begin
                    for (int b = n - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
                    if (rr < reps - 1) repeat (int'(g)) exp_q.push_back(4'b0010);
                end
            end
            exp_q.push_back(4'b0001);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = 4'b0000;
        end
    endtask

    // Driver: inputs on the falling edge, model on the rising edge, sample 1ns later.
    task automatic step(input logic r, input logic s, input logic [7:0] p,
                        input logic [3:0] l, input logic [3:0] rp, input logic [3:0] g,
                        input bit use_model);
        @(negedge clk);
        reset       = r;
        bus.start   = s;
        bus.pattern = p;
        bus.len     = l;
        bus.rpt     = rp;
        bus.gap     = g;
        @(posedge clk);
        model_edge(r, s, p, l, rp, g);
        #1;
        if (use_model) chk("outs", 32'(outs()), 32'(cur));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
    endtask

    initial begin
        logic [15:0] xs;
        logic [15:0] fs;
        logic [3:0]  det;
        int          done_cyc;
        int          done_cnt;
        int          run;
        int          max_run;
        logic        saw_done;

        n_chk       = 0;
        n_fail      = 0;
        cur         = 4'b0000;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.rpt     = '0;
        bus.gap     = '0;

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("rst_state", 32'(bus.dbg_state), 32'd0);
        idle(2);

        // Directed vectors: inputs at an edge -> {x,frame,busy,done} in the next cycle.
        tbl[0]  = '{1'b1, 1'b1, 8'h0B, 4'd4,  4'd1, 4'd0, 4'b0000}; // reset beats start
        tbl[1]  = '{1'b0, 1'b1, 8'h0B, 4'd4,  4'd1, 4'd0, 4'b1110};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0110};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b1110};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b1110};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0001};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0000};
        tbl[7]  = '{1'b0, 1'b1, 8'h0B, 4'd0,  4'd1, 4'd0, 4'b0001}; // len=0
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0000};
        tbl[9]  = '{1'b0, 1'b1, 8'h0B, 4'd4,  4'd1, 4'd0, 4'b1110};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0110};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0000}; // abort
        tbl[12] = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0000}; // no done
        tbl[13] = '{1'b0, 1'b1, 8'hA5, 4'd12, 4'd1, 4'd0, 4'b1110}; // len clamps to 8
        tbl[14] = '{1'b0, 1'b0, 8'h00, 4'd0,  4'd0, 4'd0, 4'b0110};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].pattern, tbl[i].len,
                 tbl[i].rpt, tbl[i].gap, 1'b0);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        idle(10);

        // rpt=2, gap=2: 1011 00 1011, done on cycle 11.
        xs = '0; fs = '0; done_cyc = 0;
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd2, 4'd2, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) idle(1);
            xs = {xs[14:0], bus.x};
            fs = {fs[14:0], bus.frame};
            if (bus.done && done_cyc == 0) done_cyc = k;
        end
        chk("gap_x", 32'(xs[11:2]), 32'(10'b1011001011));
        chk("gap_frame", 32'(fs[11:2]), 32'(10'b1111001111));
        chk("gap_done_cyc", 32'(done_cyc), 32'd11);
        idle(2);

        // rpt=3, gap=0: twelve back-to-back frame cycles, one done.
        xs = '0; run = 0; max_run = 0; done_cnt = 0;
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd3, 4'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) idle(1);
            if (bus.frame) begin
                run++;
                xs = {xs[14:0], bus.x};
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (bus.done) done_cnt++;
        end
        chk("b2b_run", 32'(max_run), 32'd12);
        chk("b2b_bits", 32'(xs[11:0]), 32'h0BBB);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd1);

        // start while busy is ignored; start in the done cycle is accepted.
        xs = '0;
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd1, 4'd0, 1'b1);
        xs = {xs[14:0], bus.x};
        step(1'b0, 1'b0, 8'h0B, 4'd4, 4'd1, 4'd0, 1'b1);
        xs = {xs[14:0], bus.x};
        step(1'b0, 1'b1, 8'hFF, 4'd8, 4'd5, 4'd3, 1'b1);
        xs = {xs[14:0], bus.x};
        step(1'b0, 1'b0, 8'hFF, 4'd8, 4'd5, 4'd3, 1'b1);
        xs = {xs[14:0], bus.x};
        chk("ign_bits", 32'(xs[3:0]), 32'hB);
        step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("ign_done", 32'(bus.done), 32'd1);
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd1, 4'd0, 1'b1);
        chk("done_restart", 32'({bus.x, bus.busy}), 32'b11);
        idle(6);

        // Reset on cycle 3 aborts silently; the next 1011 is detected.
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd2, 4'd1, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("abort_outs", 32'(outs()), 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        det = '0;
        step(1'b0, 1'b1, 8'h0B, 4'd4, 4'd1, 4'd0, 1'b1);
        if (bus.frame) det = {det[2:0], bus.x};
        for (int k = 0; k < 3; k++) begin
            idle(1);
            if (bus.frame) det = {det[2:0], bus.x};
        end
        chk("det_y", 32'(det == 4'b1011), 32'd1);
        idle(3);

        // Random traffic, inputs wiggling freely while busy.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 4)),
                 4'($urandom_range(0, 3)),
                 1'b1);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
